// File: rtl/rr_encoder_arbiter.sv
// Round-robin arbiter: grants one requester at a time (one-hot + binary index), held until done or request drop.
// Optional ARB_TIMEOUT_EN macro bounds grant length to TIMEOUT cycles and pulses timeout on a forced release.
module rr_encoder_arbiter #(
    parameter int unsigned OUT_SIZE = 2,
    parameter int unsigned IN_SIZE  = 1 << OUT_SIZE,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [IN_SIZE-1:0]  req,
    input  logic                done,
    output logic [IN_SIZE-1:0]  grant,
    output logic [OUT_SIZE-1:0] grant_idx,
    output logic                grant_valid,
    output logic                timeout
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t              r_state,       w_state_nxt;
    logic [OUT_SIZE-1:0] r_ptr,         w_ptr_nxt;
    logic [IN_SIZE-1:0]  r_grant,       w_grant_nxt;
    logic [OUT_SIZE-1:0] r_grant_idx,   w_grant_idx_nxt;
    logic                r_grant_valid, w_grant_valid_nxt;

    logic                w_pick_found;
    logic [OUT_SIZE-1:0] w_pick_idx;
    logic                w_release;
    logic                w_force;

    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("TIMEOUT must be >= 1");
    end

    // First requester at or after the pointer, wrapping around naturally.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_idx   = '0;
        for (int unsigned k = 0; k < IN_SIZE; k++) begin
            if (!w_pick_found && req[OUT_SIZE'(r_ptr + OUT_SIZE'(k))]) begin
                w_pick_found = 1'b1;
                w_pick_idx   = OUT_SIZE'(r_ptr + OUT_SIZE'(k));
            end
        end
    end

    assign w_release = done | ~req[r_grant_idx];

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;

    // Normal release wins over the forced one, so no pulse when both coincide.
    assign w_force = (r_state == S_GRANT) && !w_release && (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_cnt     <= (r_state == S_GRANT) ? r_cnt + CNT_W'(1) : '0;
            r_timeout <= w_force;
        end
    end

    assign timeout = r_timeout;
`else
    assign w_force = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_grant       <= '0;
            r_grant_idx   <= '0;
            r_grant_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_idx   <= w_grant_idx_nxt;
            r_grant_valid <= w_grant_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_ptr_nxt         = r_ptr;
        w_grant_nxt       = r_grant;
        w_grant_idx_nxt   = r_grant_idx;
        w_grant_valid_nxt = r_grant_valid;
        case (r_state)
            S_IDLE: begin
                if (enable && w_pick_found) begin
                    w_state_nxt       = S_GRANT;
                    w_grant_nxt       = IN_SIZE'(1) << w_pick_idx;
                    w_grant_idx_nxt   = w_pick_idx;
                    w_grant_valid_nxt = 1'b1;
                end
            end
            S_GRANT: begin
                // Leaving GRANT always passes through IDLE, giving the turnaround cycle.
                if (w_release || w_force) begin
                    w_state_nxt       = S_IDLE;
                    w_ptr_nxt         = r_grant_idx + OUT_SIZE'(1);
                    w_grant_nxt       = '0;
                    w_grant_idx_nxt   = '0;
                    w_grant_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt       = S_IDLE;
                w_grant_nxt       = '0;
                w_grant_idx_nxt   = '0;
                w_grant_valid_nxt = 1'b0;
            end
        endcase
    end

    assign grant       = r_grant;
    assign grant_idx   = r_grant_idx;
    assign grant_valid = r_grant_valid;

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// Scoreboard bench for rr_encoder_arbiter: directed scenarios then random traffic against a behavioural model.
module tb_rr_encoder_arbiter;

    localparam int unsigned OUT_SIZE = 2;
    localparam int unsigned IN_SIZE  = 4;
    localparam int unsigned TIMEOUT  = 4;

    typedef struct {
        logic [IN_SIZE-1:0]  grant;
        logic [OUT_SIZE-1:0] idx;
        logic                valid;
        logic                to;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                enable = 1'b0;
    logic [IN_SIZE-1:0]  req = '0;
    logic                done = 1'b0;
    logic [IN_SIZE-1:0]  grant;
    logic [OUT_SIZE-1:0] grant_idx;
    logic                grant_valid;
    logic                timeout;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Behavioural model state: owner index (-1 = none), pointer, cycles held, timeout pulse.
    int   m_owner = -1;
    int   m_ptr   = 0;
    int   m_held  = 0;
    bit   m_to    = 1'b0;

    rr_encoder_arbiter #(
        .OUT_SIZE (OUT_SIZE),
        .IN_SIZE  (IN_SIZE),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
        m_to    = 1'b0;
    endfunction

    function automatic void model_step();
        bit rel;
        bit forced;
        int pick;
        if (rst) begin
            model_reset();
        end else if (m_owner >= 0) begin
            rel    = done || !req[m_owner];
            forced = 1'b0;
`ifdef ARB_TIMEOUT_EN
            if (!rel && (m_held + 1 == int'(TIMEOUT))) forced = 1'b1;
`endif
            m_to = forced;
            if (rel || forced) begin
                m_ptr   = (m_owner + 1) % int'(IN_SIZE);
                m_owner = -1;
            end else begin
                m_held++;
            end
        end else begin
            m_to = 1'b0;
            pick = -1;
            if (enable) begin
                for (int i = m_ptr; i < int'(IN_SIZE); i++) if (pick < 0 && req[i]) pick = i;
                for (int i = 0; i < int'(IN_SIZE); i++)     if (pick < 0 && req[i]) pick = i;
            end
            if (pick >= 0) begin
                m_owner = pick;
                m_held  = 0;
            end
        end
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.valid = (m_owner >= 0);
        e.grant = e.valid ? (IN_SIZE'(1) << m_owner) : '0;
        e.idx   = e.valid ? OUT_SIZE'(m_owner) : '0;
        e.to    = m_to;
        exp_q.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        push_exp();
        @(negedge clk);
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        model_reset();
        push_exp();
        tick();
        rst = 1'b0;
    endtask

    // Monitor: pops one expectation per presented sample (clock edge or async reset).
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or posedge rst);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (grant !== e.grant || grant_idx !== e.idx || grant_valid !== e.valid || timeout !== e.to) begin
                    n_miss++;
                    $display("FAIL vec%0d t=%0t: got grant=%b idx=%0d valid=%b timeout=%b, need grant=%b idx=%0d valid=%b timeout=%b",
                             n_vec, $time, grant, grant_idx, grant_valid, timeout, e.grant, e.idx, e.valid, e.to);
                end
            end
        end
    end

    initial begin
        @(negedge clk);
        async_reset();

        // Reset mid-grant, then a fresh grant to requester 3.
        enable = 1'b1; req = 4'b0100;
        tick(); tick();
        req = 4'b1000;
        async_reset();
        tick(); tick();
        done = 1'b1; tick(); done = 1'b0;

        // Pointer 0 with two requesters, then pointer at 3.
        async_reset();
        req = 4'b0101;
        tick(); tick();
        done = 1'b1; tick(); done = 1'b0;
        tick(); tick();
        done = 1'b1; tick(); done = 1'b0;

        // Wrap-around from pointer 3.
        req = 4'b0011;
        tick();
        done = 1'b1; tick(); done = 1'b0;
        tick();
        done = 1'b1; tick(); done = 1'b0;

        // Full rotation with all requesting.
        async_reset();
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            tick();
            done = 1'b1; tick(); done = 1'b0;
        end

        // Enable gating, and enable dropping mid-grant.
        async_reset();
        enable = 1'b0; req = 4'b0010;
        repeat (5) tick();
        enable = 1'b1; tick();
        enable = 1'b0; tick(); tick();
        done = 1'b1; tick(); done = 1'b0;
        tick();

        // Long hold with no release (timeout boundary when enabled).
        async_reset();
        enable = 1'b1; req = 4'b0001;
        repeat (12) tick();
        req = 4'b0000;
        tick(); tick();

        // Simultaneous done and request drop.
        req = 4'b0100; tick();
        req = 4'b0000; done = 1'b1; tick(); done = 1'b0;
        tick();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(399) == 0) async_reset();
            enable = ($urandom_range(7) != 0);
            req    = IN_SIZE'($urandom);
            if (m_owner >= 0 && $urandom_range(7) != 0) req[m_owner] = 1'b1;
            done   = ($urandom_range(5) == 0);
            tick();
        end
        done = 1'b0; req = '0;

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending expectations, need 0", exp_q.size());
        end
        if (n_vec < 12) begin
            n_miss++;
            $display("FAIL coverage: got %0d vectors, need at least 12", n_vec);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
